// File: rtl/uart_seq_pkg.sv
// Shared types and constants for the UART message sequencer.
// UART_SEQ_CRLF_EN selects a CR+LF terminator (11-byte line) instead of LF only (10 bytes).
package uart_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } state_t;

    localparam logic [7:0] CHR_F          = 8'h46;
    localparam logic [7:0] CHR_O          = 8'h4F;
    localparam logic [7:0] CHR_CR         = 8'h0D;
    localparam logic [7:0] CHR_LF         = 8'h0A;
    localparam logic [7:0] HEX_BASE_NUM   = 8'h30;
    localparam logic [7:0] HEX_BASE_ALPHA = 8'h37;

`ifdef UART_SEQ_CRLF_EN
    localparam logic [3:0] MSG_LEN = 4'd11;
`else
    localparam logic [3:0] MSG_LEN = 4'd10;
`endif

endpackage

// File: rtl/hex_to_ascii.sv
// Combinational nibble to uppercase ASCII hex digit converter.
module hex_to_ascii
    import uart_seq_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    assign o_ascii = (i_nibble < 4'd10) ? (HEX_BASE_NUM + {4'b0000, i_nibble})
                                        : (HEX_BASE_ALPHA + {4'b0000, i_nibble});

endmodule

// File: rtl/uart_msg_sequencer.sv
// Streams one MAX31855 frame as an ASCII hex line (digits, fault char, terminator) into the UART.
// Define UART_SEQ_CRLF_EN to end each line with CR+LF instead of LF alone.
module uart_msg_sequencer
    import uart_seq_pkg::*;
#(
    parameter int MSG_HEX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_valid,
    input  logic [31:0] frame,
    input  logic        tx_ready,
    input  logic        tx_done_tick,
    output logic        tx_start,
    output logic [7:0]  w_data,
    output logic        busy,
    output logic        msg_done_tick,
    output logic        overrun_tick
);

    state_t      r_state;
    state_t      w_stateNext;
    logic [3:0]  r_idx;
    logic [3:0]  w_idxNext;
    logic [31:0] r_shadow;
    logic [31:0] w_shadowNext;
    logic [7:0]  r_byte;
    logic [7:0]  w_byteNext;
    logic        r_msgDone;
    logic        w_lastByte;
    logic        w_load;
    logic        w_advance;
    logic        w_finish;
    logic [3:0]  w_nibble;
    logic [7:0]  w_hexChar;

    assign w_lastByte = (r_idx == (MSG_LEN - 4'd1));

    always_comb begin
        w_stateNext  = r_state;
        w_idxNext    = r_idx;
        w_shadowNext = r_shadow;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_finish     = 1'b0;
        tx_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_valid) begin
                    w_load       = 1'b1;
                    w_shadowNext = frame;
                    w_idxNext    = 4'd0;
                    w_stateNext  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    tx_start    = 1'b1;
                    w_stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx_done_tick) begin
                    if (w_lastByte) begin
                        w_finish    = 1'b1;
                        w_stateNext = ST_IDLE;
                    end else begin
                        w_advance   = 1'b1;
                        w_idxNext   = r_idx + 4'd1;
                        w_stateNext = ST_SEND;
                    end
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Decode from the next-cycle index/shadow so the registered byte is ready with the state change.
    always_comb begin
        w_nibble = 4'h0;
        for (int i = 0; i < MSG_HEX; i++) begin
            if (w_idxNext == 4'(i)) begin
                w_nibble = w_shadowNext[(MSG_HEX-1-i)*4 +: 4];
            end
        end
    end

    hex_to_ascii u_hexToAscii (
        .i_nibble (w_nibble),
        .o_ascii  (w_hexChar)
    );

    always_comb begin
        w_byteNext = CHR_LF;
        if (w_idxNext < 4'(MSG_HEX)) begin
            w_byteNext = w_hexChar;
        end else if (w_idxNext == 4'(MSG_HEX)) begin
            w_byteNext = w_shadowNext[16] ? CHR_F : CHR_O;
        end
`ifdef UART_SEQ_CRLF_EN
        else if (w_idxNext == 4'(MSG_HEX + 1)) begin
            w_byteNext = CHR_CR;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= 4'd0;
            r_shadow  <= 32'd0;
            r_byte    <= 8'h00;
            r_msgDone <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_idx     <= w_idxNext;
            r_shadow  <= w_shadowNext;
            r_msgDone <= w_finish;
            if (w_load || w_advance) begin
                r_byte <= w_byteNext;
            end
        end
    end

    assign w_data        = r_byte;
    assign busy          = (r_state != ST_IDLE);
    assign msg_done_tick = r_msgDone;
    assign overrun_tick  = frame_valid && busy;

endmodule
